// File: rtl/request_batch_queue_if.sv
// rtl/request_batch_queue_if.sv - request/batch handshake bundle between requesters, queue and arbiter
// master: drives req, head_clr, out_ready; observes queue status
// slave : the queue; drives out_valid, out_req, pending, count, is_full, is_empty
interface request_batch_queue_if #(
    parameter int N     = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0]  req;
    logic [N-1:0]  head_clr;
    logic          out_ready;
    logic          out_valid;
    logic [N-1:0]  out_req;
    logic [N-1:0]  pending;
    logic [CW-1:0] count;
    logic          is_full;
    logic          is_empty;

    modport master (
        output req, head_clr, out_ready,
        input  out_valid, out_req, pending, count, is_full, is_empty
    );

    modport slave (
        input  req, head_clr, out_ready,
        output out_valid, out_req, pending, count, is_full, is_empty
    );
endinterface

// File: rtl/request_batch_queue.sv
// rtl/request_batch_queue.sv - arrival-ordered queue of request batches feeding an arbiter
// clk, rst_n : clock, synchronous active-low reset
// bus.req, bus.head_clr, bus.out_ready : level requests, head-bit retire, head pop
// bus.out_valid, bus.out_req : head batch presentation
// bus.pending, bus.count, bus.is_full, bus.is_empty : queue status (all registered)
module request_batch_queue #(
    parameter int N               = 4,
    parameter int DEPTH           = 4,
    parameter bit DROP_ON_RELEASE = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    request_batch_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [N-1:0]  q      [DEPTH];
    logic [N-1:0]  q_next [DEPTH];
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next;
    logic [CW-1:0] slot;
    logic [N-1:0]  pending_r;
    logic [N-1:0]  pending_next;
    logic [N-1:0]  out_req_r;
    logic          out_valid_r;
    logic          is_full_r;
    logic          is_empty_r;
    logic [N-1:0]  keep_mask;
    logic [N-1:0]  head_next;
    logic [N-1:0]  new_req;
    logic          pop_eff;
    logic          push;

    always_comb begin
        // Released requesters are withdrawn from every entry when dropping is enabled.
        keep_mask = DROP_ON_RELEASE ? bus.req : '1;
        head_next = q[0] & ~(out_valid_r ? bus.head_clr : '0) & keep_mask;
        // A head that has been fully retired or withdrawn leaves on its own.
        pop_eff   = (count_r != '0) && (bus.out_ready || (head_next == '0));
        // Registered pending means anything popped this cycle re-enters a cycle later.
        new_req   = bus.req & ~pending_r;
        push      = (new_req != '0) && ((count_r < DEPTH_C) || pop_eff);
        slot      = count_r - CW'(pop_eff);

        for (int i = 0; i < DEPTH; i++) begin
            q_next[i] = '0;
        end
        if (pop_eff) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                q_next[i] = q[i + 1] & keep_mask;
            end
            q_next[DEPTH - 1] = '0;
        end else begin
            q_next[0] = head_next;
            for (int i = 1; i < DEPTH; i++) begin
                q_next[i] = q[i] & keep_mask;
            end
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot == CW'(i)) begin
                    q_next[i] = new_req;
                end
            end
        end

        count_next   = count_r - CW'(pop_eff) + CW'(push);
        pending_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_next = pending_next | q_next[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
            count_r     <= '0;
            pending_r   <= '0;
            out_req_r   <= '0;
            out_valid_r <= 1'b0;
            is_full_r   <= 1'b0;
            is_empty_r  <= 1'b1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= q_next[i];
            end
            count_r     <= count_next;
            pending_r   <= pending_next;
            // A zero head is still a stored entry but is never presented.
            out_req_r   <= q_next[0];
            out_valid_r <= (q_next[0] != '0);
            is_full_r   <= (count_next == DEPTH_C);
            is_empty_r  <= (count_next == '0);
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_req   = out_req_r;
    assign bus.pending   = pending_r;
    assign bus.count     = count_r;
    assign bus.is_full   = is_full_r;
    assign bus.is_empty  = is_empty_r;
endmodule

// File: tb/tb_request_batch_queue.sv
// tb/tb_request_batch_queue.sv - directed self-checking bench for request_batch_queue
module tb_request_batch_queue;
    logic clk;
    logic rst_n;
    int   ncmp;
    int   nerr;

    request_batch_queue_if #(.N(4), .DEPTH(4)) bus ();
    request_batch_queue_if #(.N(4), .DEPTH(4)) bus2 ();

    assign bus2.req       = bus.req;
    assign bus2.head_clr  = bus.head_clr;
    assign bus2.out_ready = bus.out_ready;

    request_batch_queue #(.N(4), .DEPTH(4), .DROP_ON_RELEASE(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    request_batch_queue #(.N(4), .DEPTH(4), .DROP_ON_RELEASE(1'b0)) dut_keep (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = 4'b0000;
        bus.head_clr = 4'b0000;
        bus.out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic fill_four();
        bus.req = 4'b0001; step();
        bus.req = 4'b0011; step();
        bus.req = 4'b0111; step();
        bus.req = 4'b1111; step();
    endtask

    task automatic test_reset();
        do_reset();
        ncmp++; if (bus.count !== 3'd0) begin nerr++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        ncmp++; if (bus.is_empty !== 1'b1) begin nerr++; $display("FAIL reset_is_empty got=%b exp=1", bus.is_empty); end
        ncmp++; if (bus.is_full !== 1'b0) begin nerr++; $display("FAIL reset_is_full got=%b exp=0", bus.is_full); end
        ncmp++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        ncmp++; if (bus.out_req !== 4'b0000) begin nerr++; $display("FAIL reset_out_req got=%b exp=0000", bus.out_req); end
        ncmp++; if (bus.pending !== 4'b0000) begin nerr++; $display("FAIL reset_pending got=%b exp=0000", bus.pending); end
    endtask

    task automatic test_ordering();
        do_reset();
        bus.req = 4'b0001; step();
        ncmp++; if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL latency_out_valid got=%b exp=1", bus.out_valid); end
        ncmp++; if (bus.out_req !== 4'b0001) begin nerr++; $display("FAIL latency_out_req got=%b exp=0001", bus.out_req); end
        bus.req = 4'b0011; step();
        bus.req = 4'b0111; step();
        step();
        ncmp++; if (bus.count !== 3'd3) begin nerr++; $display("FAIL order_count got=%0d exp=3", bus.count); end
        ncmp++; if (bus.pending !== 4'b0111) begin nerr++; $display("FAIL order_pending got=%b exp=0111", bus.pending); end
        ncmp++; if (bus.is_empty !== 1'b0) begin nerr++; $display("FAIL order_is_empty got=%b exp=0", bus.is_empty); end
        bus.out_ready = 1'b1; step();
        ncmp++; if (bus.out_req !== 4'b0010) begin nerr++; $display("FAIL order_second_head got=%b exp=0010", bus.out_req); end
        ncmp++; if (bus.count !== 3'd2) begin nerr++; $display("FAIL order_pop_count got=%0d exp=2", bus.count); end
        bus.out_ready = 1'b0; step();
        ncmp++; if (bus.count !== 3'd3) begin nerr++; $display("FAIL order_requeue_count got=%0d exp=3", bus.count); end
        ncmp++; if (bus.out_req !== 4'b0010) begin nerr++; $display("FAIL order_requeue_head got=%b exp=0010", bus.out_req); end
        bus.out_ready = 1'b1; step();
        ncmp++; if (bus.out_req !== 4'b0100) begin nerr++; $display("FAIL order_third_head got=%b exp=0100", bus.out_req); end
        step();
        ncmp++; if (bus.out_req !== 4'b0001) begin nerr++; $display("FAIL order_tail_head got=%b exp=0001", bus.out_req); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_full_deferral();
        do_reset();
        fill_four();
        ncmp++; if (bus.count !== 3'd4) begin nerr++; $display("FAIL full_count got=%0d exp=4", bus.count); end
        ncmp++; if (bus.is_full !== 1'b1) begin nerr++; $display("FAIL full_is_full got=%b exp=1", bus.is_full); end
        bus.req = 4'b0111; step();
        ncmp++; if (bus.count !== 3'd4) begin nerr++; $display("FAIL drop_count got=%0d exp=4", bus.count); end
        ncmp++; if (bus.pending !== 4'b0111) begin nerr++; $display("FAIL drop_pending got=%b exp=0111", bus.pending); end
        bus.req = 4'b1111; step();
        ncmp++; if (bus.pending !== 4'b0111) begin nerr++; $display("FAIL defer_pending got=%b exp=0111", bus.pending); end
        ncmp++; if (bus.count !== 3'd4) begin nerr++; $display("FAIL defer_count got=%0d exp=4", bus.count); end
        bus.out_ready = 1'b1; step();
        ncmp++; if (bus.count !== 3'd4) begin nerr++; $display("FAIL swap_count got=%0d exp=4", bus.count); end
        ncmp++; if (bus.pending !== 4'b1110) begin nerr++; $display("FAIL swap_pending got=%b exp=1110", bus.pending); end
        ncmp++; if (bus.out_req !== 4'b0010) begin nerr++; $display("FAIL swap_head got=%b exp=0010", bus.out_req); end
        bus.out_ready = 1'b0; step();
        ncmp++; if (bus.count !== 3'd4) begin nerr++; $display("FAIL full_hold_count got=%0d exp=4", bus.count); end
        ncmp++; if (bus.pending !== 4'b1110) begin nerr++; $display("FAIL full_hold_pending got=%b exp=1110", bus.pending); end
        bus.out_ready = 1'b1; step();
        ncmp++; if (bus.out_req !== 4'b0100) begin nerr++; $display("FAIL b2b_head got=%b exp=0100", bus.out_req); end
        ncmp++; if (bus.pending !== 4'b1101) begin nerr++; $display("FAIL b2b_pending got=%b exp=1101", bus.pending); end
        bus.out_ready = 1'b0; step();
        bus.out_ready = 1'b1; step();
        ncmp++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL zero_head_valid got=%b exp=0", bus.out_valid); end
        ncmp++; if (bus.count !== 3'd4) begin nerr++; $display("FAIL zero_head_count got=%0d exp=4", bus.count); end
        bus.out_ready = 1'b0; step();
        ncmp++; if (bus.out_req !== 4'b1000) begin nerr++; $display("FAIL auto_pop_head got=%b exp=1000", bus.out_req); end
        ncmp++; if (bus.count !== 3'd4) begin nerr++; $display("FAIL auto_pop_count got=%0d exp=4", bus.count); end
        ncmp++; if (bus.pending !== 4'b1111) begin nerr++; $display("FAIL auto_pop_pending got=%b exp=1111", bus.pending); end
    endtask

    task automatic test_partial_retire();
        do_reset();
        bus.req = 4'b0110; step();
        bus.req = 4'b1110; step();
        ncmp++; if (bus.out_req !== 4'b0110) begin nerr++; $display("FAIL retire_start_head got=%b exp=0110", bus.out_req); end
        bus.head_clr = 4'b0010; step();
        ncmp++; if (bus.out_req !== 4'b0100) begin nerr++; $display("FAIL retire_partial_head got=%b exp=0100", bus.out_req); end
        ncmp++; if (bus.count !== 3'd2) begin nerr++; $display("FAIL retire_partial_count got=%0d exp=2", bus.count); end
        bus.head_clr = 4'b0100; step();
        ncmp++; if (bus.out_req !== 4'b1000) begin nerr++; $display("FAIL retire_auto_head got=%b exp=1000", bus.out_req); end
        ncmp++; if (bus.count !== 3'd2) begin nerr++; $display("FAIL retire_auto_count got=%0d exp=2", bus.count); end
        ncmp++; if (bus.pending !== 4'b1010) begin nerr++; $display("FAIL retire_auto_pending got=%b exp=1010", bus.pending); end
        bus.head_clr = 4'b0000;
    endtask

    task automatic test_withdraw();
        do_reset();
        bus.req = 4'b0001; step();
        bus.req = 4'b0011; step();
        bus.req = 4'b0111; step();
        bus.req = 4'b0101; step();
        ncmp++; if (bus.count !== 3'd3) begin nerr++; $display("FAIL wd_count got=%0d exp=3", bus.count); end
        ncmp++; if (bus.pending !== 4'b0101) begin nerr++; $display("FAIL wd_pending got=%b exp=0101", bus.pending); end
        ncmp++; if (bus2.pending !== 4'b0111) begin nerr++; $display("FAIL keep_pending got=%b exp=0111", bus2.pending); end
        bus.req = 4'b0100; bus.out_ready = 1'b1; step();
        ncmp++; if (bus.count !== 3'd2) begin nerr++; $display("FAIL wd_pop_count got=%0d exp=2", bus.count); end
        ncmp++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL wd_zero_head_valid got=%b exp=0", bus.out_valid); end
        ncmp++; if (bus2.out_req !== 4'b0010) begin nerr++; $display("FAIL keep_head got=%b exp=0010", bus2.out_req); end
        bus.out_ready = 1'b0; step();
        ncmp++; if (bus.count !== 3'd1) begin nerr++; $display("FAIL wd_auto_count got=%0d exp=1", bus.count); end
        ncmp++; if (bus.out_req !== 4'b0100) begin nerr++; $display("FAIL wd_auto_head got=%b exp=0100", bus.out_req); end
        ncmp++; if (bus2.count !== 3'd2) begin nerr++; $display("FAIL keep_count got=%0d exp=2", bus2.count); end
        ncmp++; if (bus2.out_req !== 4'b0010) begin nerr++; $display("FAIL keep_head_hold got=%b exp=0010", bus2.out_req); end
    endtask

    task automatic test_reset_wins();
        do_reset();
        fill_four();
        ncmp++; if (bus.is_full !== 1'b1) begin nerr++; $display("FAIL rw_pre_full got=%b exp=1", bus.is_full); end
        rst_n = 1'b0; bus.out_ready = 1'b1; step();
        ncmp++; if (bus.count !== 3'd0) begin nerr++; $display("FAIL rw_count got=%0d exp=0", bus.count); end
        ncmp++; if (bus.is_empty !== 1'b1) begin nerr++; $display("FAIL rw_is_empty got=%b exp=1", bus.is_empty); end
        ncmp++; if (bus.is_full !== 1'b0) begin nerr++; $display("FAIL rw_is_full got=%b exp=0", bus.is_full); end
        ncmp++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL rw_out_valid got=%b exp=0", bus.out_valid); end
        ncmp++; if (bus.out_req !== 4'b0000) begin nerr++; $display("FAIL rw_out_req got=%b exp=0000", bus.out_req); end
        ncmp++; if (bus.pending !== 4'b0000) begin nerr++; $display("FAIL rw_pending got=%b exp=0000", bus.pending); end
        rst_n = 1'b1; bus.out_ready = 1'b0; bus.req = 4'b0000;
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        rst_n = 1'b0;
        bus.req = 4'b0000;
        bus.head_clr = 4'b0000;
        bus.out_ready = 1'b0;
        test_reset();
        test_ordering();
        test_full_deferral();
        test_partial_retire();
        test_withdraw();
        test_reset_wins();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
